// File: rtl/mesi_pkg.sv
// Shared encodings for the MESI bus controller: BUS message fields, snoop CPU events,
// listener reply codes, FSM states and small decode helpers.
package mesi_pkg;

  localparam logic [2:0] BUS_NONE    = 3'b000;
  localparam logic [2:0] BUS_RD_MISS = 3'b001;
  localparam logic [2:0] BUS_WR_MISS = 3'b010;
  localparam logic [2:0] BUS_WB      = 3'b011;
  localparam logic [2:0] BUS_INV     = 3'b100;

  localparam logic [4:0] EV_NONE = 5'b00000;
  localparam logic [4:0] EV_RM   = 5'b00001;
  localparam logic [4:0] EV_WM   = 5'b00100;
  localparam logic [4:0] EV_INV  = 5'b10000;

  localparam logic [2:0] RPL_ABORT = 3'b010;
  localparam logic [2:0] RPL_WB    = 3'b001;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GRANT,
    ST_DECODE,
    ST_WB_REQ,
    ST_SNOOP,
    ST_COLLECT,
    ST_WB_SNP,
    ST_MEM_RD,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic rd;
    logic wr;
    logic wb;
    logic inv;
  } bus_flags_t;

  // Both 3-bit fields of a BUS message are decoded independently and OR-ed.
  function automatic bus_flags_t decode_bus(input logic [5:0] msg);
    bus_flags_t f;
    f.rd  = (msg[2:0] == BUS_RD_MISS) || (msg[5:3] == BUS_RD_MISS);
    f.wr  = (msg[2:0] == BUS_WR_MISS) || (msg[5:3] == BUS_WR_MISS);
    f.wb  = (msg[2:0] == BUS_WB)      || (msg[5:3] == BUS_WB);
    f.inv = (msg[2:0] == BUS_INV)     || (msg[5:3] == BUS_INV);
    return f;
  endfunction

  function automatic logic [4:0] snoop_event(input bus_flags_t f);
    if (f.wr)       return EV_WM;
    else if (f.rd)  return EV_RM;
    else if (f.inv) return EV_INV;
    else            return EV_NONE;
  endfunction

  // Operands are always below n, so one conditional subtract implements mod n.
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
    int unsigned s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/mesi_bus_controller_arbiter.sv
// Round-robin arbiter: first set request at or after rr_ptr, wrapping, as one-hot plus index.
module mesi_rr_arbiter
  import mesi_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic                 valid,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned IW = $clog2(N);

  always_comb begin
    valid = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid && req[wrap_add(32'(rr_ptr), i, N)]) begin
        valid = 1'b1;
        grant[wrap_add(32'(rr_ptr), i, N)] = 1'b1;
        idx   = IW'(wrap_add(32'(rr_ptr), i, N));
      end
    end
  end

endmodule

// File: rtl/mesi_bus_controller.sv
// MESI shared-bus controller: grants the bus, decodes the emitter's BUS message, broadcasts
// snoop events, collects listener replies and sequences memory write-back / fill.
module mesi_bus_controller
  import mesi_pkg::*;
#(
  parameter int unsigned N_CACHES = 3
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic [N_CACHES-1:0]     req,
  input  logic [6*N_CACHES-1:0]   req_bus,
  input  logic [6*N_CACHES-1:0]   snoop_bus,
  input  logic [N_CACHES-1:0]     snoop_hit,
  input  logic                    mem_ack,
  output logic [N_CACHES-1:0]     controle,
  output logic [5*N_CACHES-1:0]   cpu_event,
  output logic                    shared_out,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [N_CACHES-1:0]     done
);

  localparam int unsigned IW = $clog2(N_CACHES);

  state_e                state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]         gnt_idx_q, gnt_idx_d;
  bus_flags_t            flags_q, flags_d;
  logic                  abort_q, abort_d;
  logic [N_CACHES-1:0]   controle_q, controle_d;
  logic [5*N_CACHES-1:0] cpu_event_q, cpu_event_d;
  logic                  shared_out_q, shared_out_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [N_CACHES-1:0]   done_q, done_d;

  logic                  arb_valid;
  logic [N_CACHES-1:0]   arb_grant;
  logic [IW-1:0]         arb_idx;

  bus_flags_t            dec, flags_cur;
  logic [5:0]            cur_msg;
  logic                  abort_now, lwb_now;

  mesi_rr_arbiter #(.N(N_CACHES)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (arb_valid),
    .grant  (arb_grant),
    .idx    (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    flags_d   = flags_q;
    abort_d   = abort_q;

    cur_msg   = req_bus[6*gnt_idx_q +: 6];
    dec       = decode_bus(cur_msg);
    // The message is latched in DECODE, so that cycle must act on the live decode.
    flags_cur = (state_q == ST_DECODE) ? dec : flags_q;

    abort_now = 1'b0;
    lwb_now   = 1'b0;
    for (int unsigned i = 0; i < N_CACHES; i++) begin
      if (snoop_bus[6*i+3 +: 3] == RPL_ABORT) abort_now = 1'b1;
      if (snoop_bus[6*i   +: 3] == RPL_WB)    lwb_now   = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_idx_d = arb_idx;
          state_d   = ST_GRANT;
        end
      end
      ST_GRANT: begin
        rr_ptr_d = IW'(wrap_add(32'(gnt_idx_q), 32'd1, N_CACHES));
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        flags_d = dec;
        if (!(flags_cur.rd || flags_cur.wr || flags_cur.wb || flags_cur.inv)) state_d = ST_DONE;
        else if (flags_cur.wb) state_d = ST_WB_REQ;
        else                   state_d = ST_SNOOP;
      end
      ST_WB_REQ: begin
        if (mem_ack)
          state_d = (flags_q.rd || flags_q.wr || flags_q.inv) ? ST_SNOOP : ST_DONE;
      end
      ST_SNOOP: state_d = ST_COLLECT;
      ST_COLLECT: begin
        abort_d = abort_now;
        if (lwb_now)                                     state_d = ST_WB_SNP;
        else if ((flags_q.rd || flags_q.wr) && !abort_now) state_d = ST_MEM_RD;
        else                                             state_d = ST_DONE;
      end
      ST_WB_SNP: begin
        if (mem_ack)
          state_d = ((flags_q.rd || flags_q.wr) && !abort_q) ? ST_MEM_RD : ST_DONE;
      end
      ST_MEM_RD: if (mem_ack) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    controle_d   = '0;
    shared_out_d = 1'b0;
    cpu_event_d  = '0;
    done_d       = '0;
    mem_wr_d     = (state_d == ST_WB_REQ) || (state_d == ST_WB_SNP);
    mem_rd_d     = (state_d == ST_MEM_RD);
    if (state_d == ST_GRANT) begin
      controle_d   = arb_grant;
      shared_out_d = |(snoop_hit & ~arb_grant);
    end
    if (state_d == ST_SNOOP) begin
      for (int unsigned j = 0; j < N_CACHES; j++) begin
        if (j != 32'(gnt_idx_q)) cpu_event_d[5*j +: 5] = snoop_event(flags_cur);
      end
    end
    if (state_d == ST_DONE) done_d[gnt_idx_q] = 1'b1;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      gnt_idx_q    <= '0;
      flags_q      <= '0;
      abort_q      <= 1'b0;
      controle_q   <= '0;
      cpu_event_q  <= '0;
      shared_out_q <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      done_q       <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_idx_q    <= gnt_idx_d;
      flags_q      <= flags_d;
      abort_q      <= abort_d;
      controle_q   <= controle_d;
      cpu_event_q  <= cpu_event_d;
      shared_out_q <= shared_out_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      done_q       <= done_d;
    end
  end

  assign controle   = controle_q;
  assign cpu_event  = cpu_event_q;
  assign shared_out = shared_out_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign done       = done_q;

endmodule
